// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and stall/flush sequencer for the 5-stage RV32 subset pipeline
//   (RI, LW, SW, BLT, ADDI, NOP). It detects load-use hazards between ID and
//   EX and taken-branch redirects in EX. It also owns the data-memory
//   request/ready handshake: it freezes the pipeline while an access is
//   outstanding and latches a sticky error if the access times out.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   id_opcode, id_rs1, id_rs2     fields of the instruction in ID
//   ex_rd, ex_MemRead             destination and LW flag of the EX instruction
//   ex_Branch, ex_taken           BLT in EX and its comparison result
//   mem_MemRead, mem_MemWrite     LW / SW in MEM
//   dmem_ready                    data memory completes the access this cycle
//   dmem_req                      data memory request
//   pc_write, pc_sel_branch       PC enable and branch-target select
//   ifid_write, ifid_flush        IF/ID enable and NOP insert
//   idex_write, idex_flush        ID/EX enable and NOP insert
//   exmem_write                   EX/MEM enable
//   memwb_bubble                  NOP insert into MEM/WB
//   mem_err                       sticky memory timeout flag
//   stall_count                   saturating count of stalled cycles
//
// FSM states
//   state    | meaning
//   RUN      | no data access outstanding beyond the current cycle
//   MEM_WAIT | access issued, waiting for dmem_ready (wcnt = cycles waited)
//   ERR      | access timed out; pipeline halted until rst

module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_MemRead,
    input  logic             ex_Branch,
    input  logic             ex_taken,
    input  logic             mem_MemRead,
    input  logic             mem_MemWrite,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_write,
    output logic             pc_sel_branch,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_RI   = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BLT  = 7'b1100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WCNT_W-1:0] wcnt, wcnt_nxt;

    logic uses_rs1, uses_rs2;
    logic load_use, redirect, mem_access, freeze, stall_inc;

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_opcode)
            OP_RI, OP_SW, OP_BLT: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_LW, OP_ADDI: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign load_use   = ex_MemRead && (ex_rd != 5'd0) &&
                        ((uses_rs1 && (id_rs1 == ex_rd)) ||
                         (uses_rs2 && (id_rs2 == ex_rd)));
    assign redirect   = ex_Branch && ex_taken;
    assign mem_access = mem_MemRead || mem_MemWrite;
    // rst drops the request in the same cycle, abandoning any access
    assign dmem_req   = mem_access && (state != ERR) && !rst;
    assign freeze     = dmem_req && !dmem_ready;

    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            RUN: begin
                if (freeze) begin
                    state_nxt = MEM_WAIT;
                    wcnt_nxt  = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_nxt = RUN;
                    wcnt_nxt  = '0;
                end else if (wcnt == WCNT_LAST) begin
                    state_nxt = ERR;
                end else begin
                    wcnt_nxt = wcnt + WCNT_W'(1);
                end
            end
            ERR: ;
            default: begin
                state_nxt = RUN;
                wcnt_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        pc_write      = 1'b1;
        pc_sel_branch = 1'b0;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_write    = 1'b1;
        idex_flush    = 1'b0;
        exmem_write   = 1'b1;
        memwb_bubble  = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end else if (state == ERR) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
        end else if (freeze) begin
            // branch/hazard decisions wait until the access completes
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (redirect) begin
            // squashing ID makes any load-use stall moot
            pc_sel_branch = 1'b1;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign stall_inc = !rst && (state != ERR) && !pc_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wcnt        <= '0;
            mem_err     <= 1'b0;
            stall_count <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (state_nxt == ERR)
                mem_err <= 1'b1;
            if (stall_inc && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    localparam logic [6:0] OP_RI   = 7'b0110011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BLT  = 7'b1100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_NOP  = 7'b0000000;
    localparam logic [6:0] OP_UND  = 7'b1111111;

    logic clk = 1'b0;
    logic rst;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic ex_MemRead, ex_Branch, ex_taken, mem_MemRead, mem_MemWrite, dmem_ready;
    logic dmem_req, pc_write, pc_sel_branch, ifid_write, ifid_flush;
    logic idex_write, idex_flush, exmem_write, memwb_bubble, mem_err;
    logic [CNT_W-1:0] stall_count;
    logic [9:0] ctrl_obs;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state: how long the pending access has been unanswered
    bit m_waiting;
    int m_unanswered;
    bit m_err;
    int m_stalls;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_rd(ex_rd), .ex_MemRead(ex_MemRead), .ex_Branch(ex_Branch),
        .ex_taken(ex_taken), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .dmem_ready(dmem_ready), .dmem_req(dmem_req), .pc_write(pc_write),
        .pc_sel_branch(pc_sel_branch), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
        .memwb_bubble(memwb_bubble), .mem_err(mem_err), .stall_count(stall_count)
    );

    // {dmem_req, pc_write, pc_sel_branch, ifid_write, ifid_flush,
    //  idex_write, idex_flush, exmem_write, memwb_bubble, mem_err}
    assign ctrl_obs = {dmem_req, pc_write, pc_sel_branch, ifid_write, ifid_flush,
                       idex_write, idex_flush, exmem_write, memwb_bubble, mem_err};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] exp_ctrl();
        bit u1, u2, lu, rd, acc;
        u1  = id_opcode inside {OP_RI, OP_LW, OP_SW, OP_BLT, OP_ADDI};
        u2  = id_opcode inside {OP_RI, OP_SW, OP_BLT};
        lu  = ex_MemRead && ex_rd != 0 &&
              ((u1 && id_rs1 == ex_rd) || (u2 && id_rs2 == ex_rd));
        rd  = ex_Branch && ex_taken;
        acc = mem_MemRead || mem_MemWrite;
        if (rst)                 return {9'b000010101, m_err} | 10'b0000000010;
        if (m_err)               return 10'b0000000001;
        if (acc && !dmem_ready)  return 10'b1000000010;
        if (rd)                  return {acc, 9'b111111100};
        if (lu)                  return {acc, 9'b000011100};
        return {acc, 9'b101010100};
    endfunction

    task automatic model_edge(input bit pcw);
        bit acc;
        acc = mem_MemRead || mem_MemWrite;
        if (rst) begin
            m_waiting = 0; m_unanswered = 0; m_err = 0; m_stalls = 0;
        end else if (!m_err) begin
            if (!pcw && m_stalls < CNT_MAX) m_stalls++;
            if (!m_waiting) begin
                if (acc && !dmem_ready) begin
                    m_waiting = 1; m_unanswered = 1;
                end
            end else if (dmem_ready) begin
                m_waiting = 0; m_unanswered = 0;
            end else begin
                m_unanswered++;
                if (m_unanswered == MEM_TIMEOUT) m_err = 1;
            end
        end
    endtask

    task automatic cycle(input string tag);
        logic [9:0] e;
        @(negedge clk);
        e = exp_ctrl();
        chk({tag, " ctrl"}, 32'(ctrl_obs), 32'(e));
        chk({tag, " stall_count"}, 32'(stall_count), 32'(m_stalls));
        @(posedge clk);
        model_edge(e[8]);
        #1;
    endtask

    task automatic idle_inputs();
        id_opcode = OP_NOP; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        ex_MemRead = 0; ex_Branch = 0; ex_taken = 0;
        mem_MemRead = 0; mem_MemWrite = 0; dmem_ready = 1;
    endtask

    task automatic do_reset();
        rst = 1;
        cycle("reset");
        rst = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        m_waiting = 0; m_unanswered = 0; m_err = 0; m_stalls = 0;
        @(posedge clk); #1;
        cycle("reset_hold");
        chk("reset stall_count", 32'(stall_count), 0);
        chk("reset mem_err", 32'(mem_err), 0);
        rst = 0;
        cycle("idle");

        // load-use on rs2 of an RI instruction: one bubble
        ex_MemRead = 1; ex_rd = 5; id_opcode = OP_RI; id_rs1 = 3; id_rs2 = 5;
        cycle("lu_rs2");
        chk("lu stall_count", 32'(stall_count), 1);
        idle_inputs();
        cycle("after_lu");

        // x0 never hazards; NOP uses neither register field
        ex_MemRead = 1; ex_rd = 0; id_opcode = OP_ADDI; id_rs1 = 0;
        cycle("lu_x0");
        ex_rd = 5; id_opcode = OP_NOP; id_rs1 = 5; id_rs2 = 5;
        cycle("lu_nop");
        id_opcode = OP_ADDI; id_rs1 = 1; id_rs2 = 5;
        cycle("addi_rs2_unused");
        chk("no_stall stall_count", 32'(stall_count), 1);

        // taken branch beats load-use
        id_opcode = OP_SW; id_rs1 = 5; ex_Branch = 1; ex_taken = 1;
        cycle("redirect_lu");
        chk("redirect stall_count", 32'(stall_count), 1);
        idle_inputs();

        // SW with three not-ready cycles; branch waits for the freeze to end
        do_reset();
        mem_MemWrite = 1; dmem_ready = 0; ex_Branch = 1; ex_taken = 1;
        repeat (3) cycle("sw_freeze");
        dmem_ready = 1;
        cycle("sw_done");
        chk("sw stall_count", 32'(stall_count), 3);
        idle_inputs();
        cycle("sw_after");

        // LW timeout into ERR
        do_reset();
        mem_MemRead = 1; dmem_ready = 0;
        repeat (MEM_TIMEOUT) cycle("lw_wait");
        chk("err mem_err", 32'(mem_err), 1);
        chk("err dmem_req", 32'(dmem_req), 0);
        ex_MemRead = 1; ex_rd = 2; id_opcode = OP_LW; id_rs1 = 2;
        repeat (3) cycle("err_hold");
        dmem_ready = 1;
        cycle("err_ready");
        chk("err stall_count frozen", 32'(stall_count), MEM_TIMEOUT);
        idle_inputs();
        do_reset();
        chk("err cleared", 32'(mem_err), 0);

        // rst during the second MEM_WAIT cycle
        mem_MemRead = 1; dmem_ready = 0;
        repeat (2) cycle("rst_wait");
        rst = 1;
        cycle("rst_in_wait");
        rst = 0;
        chk("rst_wait stall_count", 32'(stall_count), 0);
        dmem_ready = 1;
        cycle("rst_wait_after");
        idle_inputs();

        // saturation of stall_count
        ex_MemRead = 1; ex_rd = 7; id_opcode = OP_BLT; id_rs1 = 7;
        repeat (CNT_MAX + 5) cycle("sat");
        chk("sat stall_count", 32'(stall_count), CNT_MAX);
        idle_inputs();
        do_reset();

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [6:0] ops [7];
            ops = '{OP_RI, OP_LW, OP_SW, OP_BLT, OP_ADDI, OP_NOP, OP_UND};
            rst          = ($urandom_range(99) < 3);
            id_opcode    = ops[$urandom_range(6)];
            id_rs1       = 5'($urandom_range(7));
            id_rs2       = 5'($urandom_range(7));
            ex_rd        = 5'($urandom_range(7));
            ex_MemRead   = ($urandom_range(99) < 40);
            ex_Branch    = ($urandom_range(99) < 25);
            ex_taken     = $urandom_range(1);
            mem_MemRead  = ($urandom_range(99) < 25);
            mem_MemWrite = ($urandom_range(99) < 20);
            dmem_ready   = ($urandom_range(99) < 65);
            cycle("rand");
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
